// File: rtl/aftab_mem_daru_if.sv
// Bus bundle between the memory stage / datapath and the AFTAB data adjustment
// read unit. The datapath side drives the request and the memory response, the
// read unit drives the memory address/strobe and the assembled result.
// Optional macro AFTAB_DARU_SIGN_EXT_EN adds the loadSigned request bit.
interface aftab_mem_daru_if #(
  parameter int size = 32
) ();

  localparam int BW = size / 4;

  // Request and memory response, driven towards the read unit
  logic [size-1:0] addrIn;
  logic [1:0]      nBytes;
  logic            startDARU;
  logic            memReady;
  logic [BW-1:0]   dataIn;
  logic            checkMisalignedDARU;
`ifdef AFTAB_DARU_SIGN_EXT_EN
  logic            loadSigned;
`endif

  // Memory address/strobe and result, driven by the read unit
  logic [size-1:0] addrOut;
  logic [size-1:0] dataOut;
  logic            readMem;
  logic            completeDARU;
  logic            loadMisalignedFlag;

  modport master (
    output addrIn, nBytes, startDARU, memReady, dataIn, checkMisalignedDARU,
`ifdef AFTAB_DARU_SIGN_EXT_EN
    output loadSigned,
`endif
    input  addrOut, dataOut, readMem, completeDARU, loadMisalignedFlag
  );

  modport slave (
    input  addrIn, nBytes, startDARU, memReady, dataIn, checkMisalignedDARU,
`ifdef AFTAB_DARU_SIGN_EXT_EN
    input  loadSigned,
`endif
    output addrOut, dataOut, readMem, completeDARU, loadMisalignedFlag
  );

endinterface

// File: rtl/aftab_mem_daru.sv
// AFTAB Data Adjustment Read Unit.
// Reads 1..4 bytes from byte-wide memory (one byte per memReady handshake),
// assembles them little-endian and returns a zero- or sign-extended word.
// A request whose alignment check fails completes in one cycle with
// loadMisalignedFlag and no memory access.
// Optional macro AFTAB_DARU_SIGN_EXT_EN: when defined, loadSigned selects
// sign extension; when undefined the result is always zero-extended.
// All bus outputs come straight from flops.
module aftab_mem_daru #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  aftab_mem_daru_if.slave bus
);

  localparam int BW = size / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    DONE  = 2'b10,
    MISAL = 2'b11
  } state_e;

  state_e state_q, state_d;

  // Request context and assembly register
  logic [1:0]      cnt_q, cnt_d;
  logic [size-1:0] addr_q, addr_d;
  logic [1:0]      nbytes_q, nbytes_d;
  logic            sign_q, sign_d;
  logic [size-1:0] data_q, data_d;

  // Registered bus outputs
  logic [size-1:0] addr_out_q, addr_out_d;
  logic [size-1:0] data_out_q, data_out_d;
  logic            read_q, read_d;
  logic            complete_q, complete_d;
  logic            misal_q, misal_d;

  logic            sign_in_s;
  logic            start_ok_s;
  logic            misal_s;
  logic            last_byte_s;

  // Alignment rule: halfwords need an even address, words a multiple of 4;
  // single bytes and 3-byte loads are never flagged.
  function automatic logic is_misaligned(input logic [1:0] nb, input logic [1:0] lsb);
    logic res;
    case (nb)
      2'b01:   res = lsb[0];
      2'b11:   res = (lsb != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Fill every lane above the last loaded byte with zeros or with the sign
  // bit of the last loaded byte.
  function automatic logic [size-1:0] extend_word(input logic [size-1:0] raw,
                                                  input logic [1:0]      nb,
                                                  input logic            sgn);
    logic [size-1:0] res;
    logic            fill;
    res  = raw;
    fill = sgn & raw[BW * int'(nb) + BW - 1];
    for (int lane = 0; lane < 4; lane++) begin
      if (lane > int'(nb)) begin
        res[lane*BW +: BW] = {BW{fill}};
      end else begin
        res[lane*BW +: BW] = raw[lane*BW +: BW];
      end
    end
    return res;
  endfunction

`ifdef AFTAB_DARU_SIGN_EXT_EN
  assign sign_in_s = bus.loadSigned;
`else
  assign sign_in_s = 1'b0;
`endif

  assign start_ok_s  = (state_q == IDLE) && bus.startDARU;
  assign misal_s     = bus.checkMisalignedDARU && is_misaligned(bus.nBytes, bus.addrIn[1:0]);
  assign last_byte_s = (cnt_q == nbytes_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only from IDLE, one byte per memReady in READ,
  // DONE and MISAL are single-cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.startDARU) begin
          if (misal_s) begin
            state_d = MISAL;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (bus.memReady && last_byte_s) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      MISAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accepted start, byte-lane assembly during READ
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    nbytes_d = nbytes_q;
    sign_d   = sign_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (bus.startDARU) begin
          addr_d   = bus.addrIn;
          nbytes_d = bus.nBytes;
          sign_d   = sign_in_s;
          data_d   = {size{1'b0}};
          cnt_d    = 2'd0;
        end else begin
          cnt_d    = cnt_q;
        end
      end
      READ: begin
        if (bus.memReady) begin
          data_d[int'(cnt_q)*BW +: BW] = bus.dataIn;
          if (last_byte_s) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Request context and assembly registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 2'd0;
      addr_q   <= {size{1'b0}};
      nbytes_q <= 2'd0;
      sign_q   <= 1'b0;
      data_q   <= {size{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nbytes_q <= nbytes_d;
      sign_q   <= sign_d;
      data_q   <= data_d;
    end
  end

  // Output decode from the next state so the bus outputs can be registered
  // and still line up with the state they describe
  always_comb begin
    read_d     = (state_d == READ);
    complete_d = (state_d == DONE) || (state_d == MISAL);
    misal_d    = (state_d == MISAL);
    if (read_d) begin
      addr_out_d = addr_d + {{(size-2){1'b0}}, cnt_d};
    end else begin
      addr_out_d = {size{1'b0}};
    end
    if (start_ok_s) begin
      data_out_d = {size{1'b0}};
    end else if ((state_q == READ) && (state_d == DONE)) begin
      data_out_d = extend_word(data_d, nbytes_q, sign_q);
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_out_q <= {size{1'b0}};
      data_out_q <= {size{1'b0}};
      read_q     <= 1'b0;
      complete_q <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      read_q     <= read_d;
      complete_q <= complete_d;
      misal_q    <= misal_d;
    end
  end

  assign bus.addrOut            = addr_out_q;
  assign bus.dataOut            = data_out_q;
  assign bus.readMem            = read_q;
  assign bus.completeDARU       = complete_q;
  assign bus.loadMisalignedFlag = misal_q;

endmodule

// File: tb/tb_aftab_mem_daru.sv
// Self-checking bench for aftab_mem_daru: directed scenarios plus randomized
// requests, compared against a byte-memory reference model.
module tb_aftab_mem_daru;

`ifdef AFTAB_DARU_SIGN_EXT_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sign_drv = 1'b0;
  always #5 clk = ~clk;

  aftab_mem_daru_if #(.size(32)) bus ();
  aftab_mem_daru #(.size(32)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef AFTAB_DARU_SIGN_EXT_EN
  assign bus.loadSigned = sign_drv;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [logic [31:0]];

  logic [31:0] obs_addrs[$];
  int          obs_lat;
  logic [31:0] obs_data;
  logic        obs_misal, obs_read_seen, obs_stable_bad;
  logic        obs_after_read, obs_after_complete;
  logic [31:0] obs_after_data;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] h;
    if (mem.exists(a)) return mem[a];
    h = a[7:0] * 8'd29;
    h = h ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    return h;
  endfunction

  // Reference: little-endian byte sum, then extension by arithmetic mask
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] nb, input logic sgn);
    int n;
    logic [63:0] v;
    n = int'(nb) + 1;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(mem_byte(a + 32'(i))) << (8 * i));
    if (SIGN_EN && sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic exp_misal(input logic [31:0] a, input logic [1:0] nb, input logic chk);
    int n;
    n = int'(nb) + 1;
    return chk && (n == 2 || n == 4) && ((a % 32'(n)) != 32'd0);
  endfunction

  // Drive one request at a negedge; act as memory with 'stall' wait cycles per
  // byte; record what the DUT did. Also pulses start during the done cycle.
  task automatic do_load(input logic [31:0] a, input logic [1:0] nb, input logic chk,
                         input logic sgn, input int stall, input bit mid_start);
    int scnt;
    bit stalled;
    logic [31:0] stall_addr;
    obs_addrs.delete();
    obs_lat = -1; obs_data = 32'd0; obs_misal = 1'b0; obs_read_seen = 1'b0;
    obs_stable_bad = 1'b0; obs_after_read = 1'b0; obs_after_complete = 1'b0;
    obs_after_data = 32'd0;
    bus.addrIn = a; bus.nBytes = nb; bus.checkMisalignedDARU = chk; sign_drv = sgn;
    bus.startDARU = 1'b1; bus.memReady = 1'b0; bus.dataIn = 8'd0;
    scnt = 0; stalled = 1'b0; stall_addr = 32'd0;
    for (int edges = 1; edges <= 400; edges++) begin
      @(posedge clk); @(negedge clk);
      bus.startDARU = 1'b0;
      bus.addrIn = $urandom; bus.nBytes = 2'($urandom);
      bus.checkMisalignedDARU = 1'($urandom); sign_drv = 1'($urandom);
      if (bus.completeDARU) begin
        obs_lat = edges; obs_data = bus.dataOut; obs_misal = bus.loadMisalignedFlag;
        break;
      end
      if (bus.readMem) begin
        obs_read_seen = 1'b1;
        if (stalled && bus.addrOut !== stall_addr) obs_stable_bad = 1'b1;
        if (mid_start && edges == 2) bus.startDARU = 1'b1;
        if (scnt < stall) begin
          bus.memReady = 1'b0; bus.dataIn = 8'($urandom);
          stalled = 1'b1; stall_addr = bus.addrOut; scnt++;
        end else begin
          bus.memReady = 1'b1; bus.dataIn = mem_byte(bus.addrOut);
          obs_addrs.push_back(bus.addrOut); stalled = 1'b0; scnt = 0;
        end
      end else begin
        bus.memReady = 1'($urandom); bus.dataIn = 8'($urandom);
      end
    end
    if (obs_lat > 0) begin
      bus.startDARU = 1'b1; bus.checkMisalignedDARU = 1'b0; bus.nBytes = 2'b00; bus.memReady = 1'b1;
      @(posedge clk); @(negedge clk);
      obs_after_read = bus.readMem; obs_after_complete = bus.completeDARU; obs_after_data = bus.dataOut;
    end
    bus.startDARU = 1'b0; bus.memReady = 1'b0;
  endtask

  task automatic test_reset;
    bus.addrIn = 32'h0000_0100; bus.nBytes = 2'b11; bus.startDARU = 1'b1; bus.memReady = 1'b1;
    bus.dataIn = 8'h55; bus.checkMisalignedDARU = 1'b0; sign_drv = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.readMem !== 1'b0) begin errors++; $display("FAIL reset_readMem: got %b want 0", bus.readMem); end
    checks++; if (bus.addrOut !== 32'd0) begin errors++; $display("FAIL reset_addrOut: got %h want 0", bus.addrOut); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.readMem, bus.completeDARU, bus.loadMisalignedFlag} !== 3'b000 || bus.dataOut !== 32'd0)
      begin errors++; $display("FAIL reset_held: got rd/cmp/mis %b%b%b data %h want 000/0",
                               bus.readMem, bus.completeDARU, bus.loadMisalignedFlag, bus.dataOut); end
    bus.startDARU = 1'b0; bus.memReady = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.readMem !== 1'b0 || bus.completeDARU !== 1'b0)
      begin errors++; $display("FAIL reset_release_idle: got rd %b cmp %b want 0 0", bus.readMem, bus.completeDARU); end
  endtask

  task automatic test_word_load;
    bit bad;
    do_load(32'h0000_0100, 2'b11, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (obs_lat !== 5) begin errors++; $display("FAIL word_latency: got %0d want 5", obs_lat); end
    checks++; if (obs_data !== 32'h1234_5678) begin errors++; $display("FAIL word_data: got %h want 12345678", obs_data); end
    bad = (obs_addrs.size() != 4);
    if (!bad) for (int i = 0; i < 4; i++) if (obs_addrs[i] !== 32'h100 + 32'(i)) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL word_addrs: got %0d addrs want 100..103", obs_addrs.size()); end
    checks++; if (obs_after_read !== 1'b0 || obs_after_complete !== 1'b0)
      begin errors++; $display("FAIL done_start_ignored: got rd %b cmp %b want 0 0", obs_after_read, obs_after_complete); end
    checks++; if (obs_after_data !== 32'h1234_5678) begin errors++; $display("FAIL data_hold: got %h want 12345678", obs_after_data); end
  endtask

  task automatic test_sign_ext;
    logic [31:0] exp;
    do_load(32'h0000_0203, 2'b00, 1'b1, 1'b1, 0, 1'b0);
    exp = SIGN_EN ? 32'hFFFF_FF80 : 32'h0000_0080;
    checks++; if (obs_data !== exp || obs_lat !== 2) begin errors++; $display("FAIL lb_signed: got %h lat %0d want %h lat 2", obs_data, obs_lat, exp); end
    do_load(32'h0000_0203, 2'b00, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (obs_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", obs_data); end
    do_load(32'h0000_0204, 2'b01, 1'b1, 1'b1, 0, 1'b0);
    exp = SIGN_EN ? 32'hFFFF_9A34 : 32'h0000_9A34;
    checks++; if (obs_data !== exp) begin errors++; $display("FAIL lh_signed: got %h want %h", obs_data, exp); end
    do_load(32'h0000_0208, 2'b10, 1'b1, 1'b1, 0, 1'b0);
    exp = SIGN_EN ? 32'hFF83_2211 : 32'h0083_2211;
    checks++; if (obs_data !== exp || obs_lat !== 4) begin errors++; $display("FAIL l3_signed: got %h lat %0d want %h lat 4", obs_data, obs_lat, exp); end
  endtask

  task automatic test_misaligned;
    do_load(32'h0000_0102, 2'b11, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (obs_lat !== 1 || obs_misal !== 1'b1) begin errors++; $display("FAIL misal_pulse: got lat %0d flag %b want 1 1", obs_lat, obs_misal); end
    checks++; if (obs_read_seen !== 1'b0 || obs_data !== 32'd0) begin errors++; $display("FAIL misal_noread: got rd %b data %h want 0 0", obs_read_seen, obs_data); end
    checks++; if (obs_after_complete !== 1'b0) begin errors++; $display("FAIL misal_one_cycle: got cmp %b want 0", obs_after_complete); end
    do_load(32'h0000_0102, 2'b11, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (obs_misal !== 1'b0 || obs_lat !== 5 || obs_data !== model_load(32'h102, 2'b11, 1'b0))
      begin errors++; $display("FAIL unchecked_word: got flag %b lat %0d data %h want 0 5 %h", obs_misal, obs_lat, obs_data, model_load(32'h102, 2'b11, 1'b0)); end
  endtask

  task automatic test_stall_restart;
    bit bad;
    do_load(32'h0000_0300, 2'b01, 1'b1, 1'b0, 3, 1'b1);
    checks++; if (obs_stable_bad !== 1'b0) begin errors++; $display("FAIL stall_addr_stable: got moved %b want 0", obs_stable_bad); end
    checks++; if (obs_lat !== 9) begin errors++; $display("FAIL stall_latency: got %0d want 9", obs_lat); end
    bad = (obs_addrs.size() != 2) || (obs_addrs[0] !== 32'h300) || (obs_addrs[1] !== 32'h301);
    checks++; if (bad || obs_data !== model_load(32'h300, 2'b01, 1'b0))
      begin errors++; $display("FAIL stall_data: got %h (%0d bytes) want %h", obs_data, obs_addrs.size(), model_load(32'h300, 2'b01, 1'b0)); end
  endtask

  task automatic test_reset_mid_read;
    bit seen;
    bus.addrIn = 32'h0000_0400; bus.nBytes = 2'b11; bus.checkMisalignedDARU = 1'b1; sign_drv = 1'b0;
    bus.startDARU = 1'b1; bus.memReady = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.startDARU = 1'b0; bus.memReady = 1'b1; bus.dataIn = mem_byte(bus.addrOut);
    @(posedge clk); @(negedge clk);
    checks++; if (bus.addrOut !== 32'h401 || bus.readMem !== 1'b1) begin errors++; $display("FAIL second_byte_addr: got %h rd %b want 401 1", bus.addrOut, bus.readMem); end
    bus.memReady = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.readMem, bus.completeDARU, bus.loadMisalignedFlag} !== 3'b000 || bus.addrOut !== 32'd0 || bus.dataOut !== 32'd0)
      begin errors++; $display("FAIL midread_abort: got rd/cmp/mis %b%b%b addr %h data %h want zeros",
                               bus.readMem, bus.completeDARU, bus.loadMisalignedFlag, bus.addrOut, bus.dataOut); end
    @(negedge clk);
    rst = 1'b1; bus.memReady = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (bus.completeDARU || bus.readMem) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midread_no_complete: got activity %b want 0", seen); end
    bus.memReady = 1'b0;
    do_load(32'h0000_0400, 2'b11, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (obs_lat !== 5 || obs_data !== model_load(32'h400, 2'b11, 1'b0))
      begin errors++; $display("FAIL after_reset_load: got lat %0d data %h want 5 %h", obs_lat, obs_data, model_load(32'h400, 2'b11, 1'b0)); end
  endtask

  task automatic test_addr_wrap;
    bit bad;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
    do_load(32'hFFFF_FFFE, 2'b11, 1'b0, 1'b0, 0, 1'b0);
    bad = (obs_addrs.size() != 4);
    if (!bad) for (int i = 0; i < 4; i++) if (obs_addrs[i] !== exp_a[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL wrap_addrs: got %0d addrs first %h want fffffffe..00000001", obs_addrs.size(), (obs_addrs.size() > 0) ? obs_addrs[0] : 32'd0); end
    checks++; if (obs_data !== model_load(32'hFFFF_FFFE, 2'b11, 1'b0)) begin errors++; $display("FAIL wrap_data: got %h want %h", obs_data, model_load(32'hFFFF_FFFE, 2'b11, 1'b0)); end
  endtask

  task automatic test_random;
    logic [31:0] a, exp_d;
    logic [1:0]  nb;
    logic        chk, sgn, mis;
    int          stall, n, exp_lat;
    bit          bad;
    for (int it = 0; it < 40; it++) begin
      a = $urandom; if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      nb = 2'($urandom); chk = 1'($urandom); sgn = 1'($urandom);
      stall = $urandom_range(0, 2);
      do_load(a, nb, chk, sgn, stall, 1'($urandom));
      n = int'(nb) + 1;
      mis = exp_misal(a, nb, chk);
      exp_lat = mis ? 1 : 1 + n * (stall + 1);
      exp_d = mis ? 32'd0 : model_load(a, nb, sgn);
      bad = (obs_addrs.size() != (mis ? 0 : n));
      if (!bad) for (int i = 0; i < obs_addrs.size(); i++) if (obs_addrs[i] !== a + 32'(i)) bad = 1'b1;
      checks++;
      if (obs_lat !== exp_lat || obs_data !== exp_d || obs_misal !== mis || bad || obs_stable_bad
          || obs_after_read !== 1'b0 || obs_after_complete !== 1'b0 || obs_after_data !== exp_d) begin
        errors++;
        $display("FAIL random_%0d: a=%h nb=%0d chk=%b s=%b got lat %0d data %h mis %b addrs_bad %b want lat %0d data %h mis %b",
                 it, a, nb, chk, sign_drv & sgn, obs_lat, obs_data, obs_misal, bad | obs_stable_bad, exp_lat, exp_d, mis);
      end
    end
  endtask

  initial begin
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem[32'h203] = 8'h80; mem[32'h204] = 8'h34; mem[32'h205] = 8'h9A;
    mem[32'h208] = 8'h11; mem[32'h209] = 8'h22; mem[32'h20A] = 8'h83;
    test_reset();
    test_word_load();
    test_sign_ext();
    test_misaligned();
    test_stall_restart();
    test_reset_mid_read();
    test_addr_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aftab_mem_daru.md
Name: aftab_mem_daru

Overview:
- Data Adjustment Read Unit for the AFTAB datapath; the load-side counterpart of the byte-serial store unit.
- Reads 1/2/3/4 bytes from byte-wide memory, one byte per handshake, starting at a base address.
- Assembles the bytes little-endian into a size-bit word, extends it and returns it to the datapath.
- Single FSM with byte counter; sits between the memory stage and the register-file write-back mux.

Parameters:
- size, 32, datapath/address width; memory byte width is size/4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addrIn  in  size  base byte address, sampled on accepted start.
- nBytes  in  2  byte count minus one (00=1, 01=2, 10=3, 11=4), sampled on start.
- startDARU  in  1  start request, accepted only in IDLE.
- memReady  in  1  memory has valid byte on dataIn for current addrOut.
- dataIn  in  size/4  byte from memory.
- checkMisalignedDARU  in  1  enable alignment check for this request.
- loadSigned  in  1  sign-extend result (only with AFTAB_DARU_SIGN_EXT_EN), sampled on start.
- addrOut  out  size  current byte address = base + cnt while reading, else 0.
- dataOut  out  size  assembled, extended word; held until next accepted start.
- readMem  out  1  memory read strobe.
- completeDARU  out  1  one-cycle done pulse.
- loadMisalignedFlag  out  1  one-cycle misaligned-load pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, addr/nBytes/data registers=0; all outputs 0.
- States: IDLE, READ, DONE, MISAL.
- IDLE: readMem=0, addrOut=0. On startDARU=1: latch addrIn, nBytes, loadSigned; clear data register; cnt=0.
  - If checkMisalignedDARU=1 and misaligned, go to MISAL.
  - Misaligned means nBytes=01 with addr[0]=1, or nBytes=11 with addr[1:0]!=0. nBytes=00/10 never flag.
  - Otherwise go to READ.
- READ: readMem=1, addrOut=addrReg+cnt (size-bit add, wraps modulo 2^size).
  - memReady=0: hold all state.
  - memReady=1: write dataIn into byte lane cnt (bits 8*cnt+7:8*cnt). If cnt==nBytes go to DONE, else cnt+=1.
- DONE, one cycle: completeDARU=1, readMem=0, dataOut valid and extended. Always returns to IDLE.
- MISAL, one cycle: loadMisalignedFlag=1 and completeDARU=1, no read issued, dataOut=0. Returns to IDLE.
- Extension: lanes above nBytes are 0 (zero-extend) or copies of bit 8*(nBytes+1)-1 (sign-extend). 4-byte loads are unaffected.
- Latency with memReady tied high: N bytes gives start cycle + N READ cycles, then DONE; completeDARU is asserted N+1 cycles after start is sampled.
- startDARU outside IDLE: ignored, including in the DONE cycle. memReady outside READ: ignored.
- Reset mid-read: abort immediately, no completeDARU, outputs 0.

Optional Feature:
- Macro: AFTAB_DARU_SIGN_EXT_EN.
- Defined: loadSigned port present; signed/unsigned extension as above (LB/LH vs LBU/LHU).
- Undefined: loadSigned port absent; dataOut always zero-extended; a separate extension unit downstream handles sign.

Test Plan:
- addrIn=0x100, nBytes=11, memReady=1, bytes 0x78,0x56,0x34,0x12 -> addrOut 0x100..0x103, dataOut=0x12345678, completeDARU 5 cycles after start.
- addrIn=0x203, nBytes=00, loadSigned=1, byte 0x80 -> dataOut=0xFFFFFF80 (0x00000080 without macro or with loadSigned=0).
- addrIn=0x102, nBytes=11, checkMisalignedDARU=1 -> loadMisalignedFlag and completeDARU high 1 cycle, readMem never asserted; same request with checkMisalignedDARU=0 -> normal 4-byte read.
- nBytes=01, memReady low 3 cycles per byte, startDARU pulsed mid-read -> addrOut stable while stalled, second start ignored, dataOut correct 2-byte result.
- rst low during second byte of 4-byte read -> outputs 0 immediately, no completeDARU; next start completes normally.
- addrIn=0xFFFFFFFE, nBytes=11, checkMisalignedDARU=0 -> addrOut 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
